// File: rtl/ajuste_valor_hora_if.sv
// RTC write channel between the time-adjust value editor and the RTC bus controller.
interface ajuste_valor_hora_if;
  logic       wr_req;
  logic [7:0] wr_dir;
  logic [7:0] wr_dato;
  logic       wr_ack;

  modport master (output wr_req, output wr_dir, output wr_dato, input wr_ack);
  modport slave  (input wr_req, input wr_dir, input wr_dato, output wr_ack);
endinterface

// File: rtl/ajuste_valor_hora.sv
// BCD hour/minute/second editor: applies up/down presses to the selected field
// and issues one RTC write per edit, with a bounded wait for the acknowledge.
module ajuste_valor_hora #(
  parameter logic [7:0] DIR_SEG  = 8'h21,
  parameter logic [7:0] DIR_MIN  = 8'h22,
  parameter logic [7:0] DIR_HORA = 8'h23,
  parameter int         TIMEOUT  = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_ajuste,
  input  logic                       a_hora,
  input  logic                       a_min,
  input  logic                       a_seg,
  input  logic                       boton_arriba,
  input  logic                       boton_abajo,
  input  logic                       carga,
  input  logic [7:0]                 hora_in,
  input  logic [7:0]                 min_in,
  input  logic [7:0]                 seg_in,
  ajuste_valor_hora_if.master        bus,
  output logic [7:0]                 hora_bcd,
  output logic [7:0]                 min_bcd,
  output logic [7:0]                 seg_bcd,
  output logic                       ocupado,
  output logic                       error_wr
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {REPOSO, EDITA, PIDE} estado_t;
  typedef enum logic [1:0] {CAMPO_NINGUNO, CAMPO_HORA, CAMPO_MIN, CAMPO_SEG} campo_t;

  estado_t       estado_reg;
  logic [7:0]    hora_reg, min_reg, seg_reg;
  logic          wr_req_reg, ocupado_reg, error_wr_reg;
  logic [7:0]    wr_dir_reg, wr_dato_reg;
  logic [CW-1:0] cnt_reg;

  campo_t        campo;
  logic [7:0]    campo_val, campo_max, campo_dir, campo_next;
  logic          edicion;

  // Out-of-range or non-BCD contents snap to 00 on any step.
  function automatic logic [7:0] bcd_paso(input logic [7:0] v, input logic [7:0] vmax,
                                          input logic arriba);
    logic [7:0] r;
    logic [3:0] u, t;
    u = v[3:0];
    t = v[7:4];
    if (u > 4'd9 || t > 4'd9 || v > vmax)
      r = 8'h00;
    else if (arriba)
      r = (v == vmax) ? 8'h00 : (u == 4'd9) ? {t + 4'd1, 4'd0} : {t, u + 4'd1};
    else
      r = (v == 8'h00) ? vmax : (u == 4'd0) ? {t - 4'd1, 4'd9} : {t, u - 4'd1};
    return r;
  endfunction

  always_comb begin
    campo     = CAMPO_NINGUNO;
    campo_val = 8'h00;
    campo_max = 8'h59;
    campo_dir = 8'h00;
    if (a_hora) begin
      campo     = CAMPO_HORA;
      campo_val = hora_reg;
      campo_max = 8'h23;
      campo_dir = DIR_HORA;
    end else if (a_min) begin
      campo     = CAMPO_MIN;
      campo_val = min_reg;
      campo_dir = DIR_MIN;
    end else if (a_seg) begin
      campo     = CAMPO_SEG;
      campo_val = seg_reg;
      campo_dir = DIR_SEG;
    end
    campo_next = bcd_paso(campo_val, campo_max, boton_arriba);
    edicion    = (campo != CAMPO_NINGUNO) && (boton_arriba ^ boton_abajo);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      estado_reg   <= REPOSO;
      hora_reg     <= 8'h00;
      min_reg      <= 8'h00;
      seg_reg      <= 8'h00;
      wr_req_reg   <= 1'b0;
      wr_dir_reg   <= 8'h00;
      wr_dato_reg  <= 8'h00;
      ocupado_reg  <= 1'b0;
      error_wr_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      case (estado_reg)
        REPOSO: begin
          wr_req_reg  <= 1'b0;
          ocupado_reg <= 1'b0;
          if (carga) begin
            hora_reg <= hora_in;
            min_reg  <= min_in;
            seg_reg  <= seg_in;
          end
          if (en_ajuste)
            estado_reg <= EDITA;
        end
        EDITA: begin
          if (!en_ajuste) begin
            estado_reg <= REPOSO;
          end else if (edicion) begin
            case (campo)
              CAMPO_HORA: hora_reg <= campo_next;
              CAMPO_MIN:  min_reg  <= campo_next;
              CAMPO_SEG:  seg_reg  <= campo_next;
              default: ;
            endcase
            wr_dir_reg  <= campo_dir;
            wr_dato_reg <= campo_next;
            wr_req_reg  <= 1'b1;
            ocupado_reg <= 1'b1;
            cnt_reg     <= '0;
            estado_reg  <= PIDE;
          end
        end
        PIDE: begin
          // Losing en_ajuste here only changes where we land once the write ends.
          if (bus.wr_ack || cnt_reg == CNT_MAX) begin
            wr_req_reg   <= 1'b0;
            ocupado_reg  <= 1'b0;
            error_wr_reg <= !bus.wr_ack;
            estado_reg   <= en_ajuste ? EDITA : REPOSO;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: estado_reg <= REPOSO;
      endcase
    end
  end

  assign hora_bcd    = hora_reg;
  assign min_bcd     = min_reg;
  assign seg_bcd     = seg_reg;
  assign ocupado     = ocupado_reg;
  assign error_wr    = error_wr_reg;
  assign bus.wr_req  = wr_req_reg;
  assign bus.wr_dir  = wr_dir_reg;
  assign bus.wr_dato = wr_dato_reg;

endmodule

// File: doc/ajuste_valor_hora.md
Name: ajuste_valor_hora

Overview:
- Value-editing end of the time-adjust path.
- Consumes the one-hot field select (a_hora/a_min/a_seg) and the up/down button pulses.
- Keeps the BCD hour/minute/second registers shown on the display and issues one RTC write per edit through a req/ack handshake to the RTC bus controller.
- Sits between the field-select counter and the RTC write/address block; outside adjust mode it tracks RTC read values.

Parameters:
- DIR_SEG, 8'h21, RTC register address for seconds
- DIR_MIN, 8'h22, RTC register address for minutes
- DIR_HORA, 8'h23, RTC register address for hours
- TIMEOUT, 1000, max clk cycles to wait for wr_ack (10 us at 100 MHz)

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- en_ajuste  in  1  adjust mode active (hour switch on, others off)
- a_hora, a_min, a_seg  in  1 each  one-hot field select from the field-select counter
- boton_arriba, boton_abajo  in  1 each  debounced single-cycle pulses
- carga  in  1  pulse: load hora_in/min_in/seg_in
- hora_in, min_in, seg_in  in  8 each  BCD values read from RTC
- wr_ack  in  1  write accepted by RTC bus controller
- hora_bcd, min_bcd, seg_bcd  out  8 each  current BCD values
- wr_req  out  1  write request
- wr_dir  out  8  write address
- wr_dato  out  8  write data (BCD)
- ocupado  out  1  write in progress; buttons ignored
- error_wr  out  1  sticky: last write timed out

Behaviour:
- Reset (rst=0 at posedge): all values 8'h00; wr_req, ocupado, error_wr = 0; wr_dir, wr_dato = 0; timeout counter = 0; state REPOSO.
- FSM states: REPOSO, EDITA, PIDE.
- REPOSO:
  - carga=1 loads all three inputs the next cycle.
  - en_ajuste=1 -> EDITA.
- EDITA:
  - carga is ignored.
  - Field priority: hora > min > seg if more than one select is high. No select high -> buttons ignored.
  - boton_arriba xor boton_abajo -> the selected field is updated on the next edge.
  - In that same cycle: wr_dir = the field address, wr_dato = the new value, wr_req=1, ocupado=1, state -> PIDE. Latency is 1 cycle from the button to the new value and wr_req.
  - Both buttons high in the same cycle -> no change, no write.
  - en_ajuste=0 -> REPOSO.
- PIDE:
  - wr_req, wr_dir and wr_dato stay stable until wr_ack=1.
  - On the wr_ack edge: wr_req=0, ocupado=0 next cycle, error_wr=0, return to EDITA (or REPOSO if en_ajuste=0). A dropped en_ajuste does not abort the write.
  - Buttons are ignored while in PIDE.
  - If the counter reaches TIMEOUT-1 without wr_ack: wr_req=0, error_wr=1, leave PIDE. The edited value is kept.
- BCD arithmetic, units and tens handled as separate nibbles:
  - Up: units 9 -> 0 with a tens carry.
  - Down: units 0 -> 9 with a tens borrow.
  - Seconds and minutes wrap 59 -> 00 going up and 00 -> 59 going down.
  - Hours wrap 23 -> 00 going up and 00 -> 23 going down.
  - Invalid BCD loaded via carga (e.g. 8'h7A) is treated as out of range: the next up or down forces the field to 00.
- Outputs are registered, with no combinational paths from inputs to outputs.

Test Plan:
- Reset, then carga with hora_in=8'h12, min_in=8'h34, seg_in=8'h56 -> hora_bcd=12, min_bcd=34, seg_bcd=56 one cycle later; wr_req stays 0.
- en_ajuste=1, a_min=1, min=8'h59, boton_arriba -> next cycle min_bcd=8'h00, wr_req=1, wr_dir=8'h22, wr_dato=8'h00; wr_ack after 3 cycles -> wr_req=0, ocupado=0.
- a_hora=1, hora=8'h00, boton_abajo -> hora_bcd=8'h23, wr_dir=8'h23; a second boton_abajo while ocupado=1 is ignored (value stays 23).
- a_seg=1, seg=8'h09, boton_arriba -> seg=8'h10; both buttons pressed together -> no change and no wr_req.
- Write never acked -> wr_req drops after exactly TIMEOUT cycles and error_wr=1; a later acked write clears error_wr.
- rst=0 during PIDE -> next edge all values 00, wr_req=0, state REPOSO; en_ajuste=0 during PIDE -> write still completes on wr_ack.
